// File: rtl/bpu_gen2_if.sv
// Fetch/execute-facing bundle of the bpu_gen2 branch prediction unit.
// master = fetch/execute side, slave = the predictor.
interface bpu_gen2_if #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 5
);
  logic                flush_i;
  logic                pc_valid_i;
  logic [XLEN-1:0]     pc_i;
  logic                res_valid_i;
  logic [XLEN-1:0]     res_pc_i;
  logic [IDX_BITS-1:0] res_index_i;
  logic [XLEN-1:0]     res_target_i;
  logic                res_taken_i;
  logic                res_mispredict_i;
  logic [1:0]          res_type_i;
  logic [XLEN-1:0]     pred_pc_o;
  logic [IDX_BITS-1:0] pred_index_o;
  logic [XLEN-1:0]     pred_target_o;
  logic                pred_taken_o;

  modport master (
    output flush_i, pc_valid_i, pc_i, res_valid_i, res_pc_i, res_index_i,
           res_target_i, res_taken_i, res_mispredict_i, res_type_i,
    input  pred_pc_o, pred_index_o, pred_target_o, pred_taken_o
  );

  modport slave (
    input  flush_i, pc_valid_i, pc_i, res_valid_i, res_pc_i, res_index_i,
           res_target_i, res_taken_i, res_mispredict_i, res_type_i,
    output pred_pc_o, pred_index_o, pred_target_o, pred_taken_o
  );
endinterface

// File: rtl/bpu_gen2.sv
// gshare + tagged direct-mapped BTB branch predictor, same-cycle lookup.
// Optional return address stack enabled by defining BPU_RAS_EN.
module bpu_gen2 #(
  parameter int XLEN      = 32,
  parameter int IDX_BITS  = 5,
  parameter int BTB_BITS  = 4,
  parameter int RAS_DEPTH = 4
) (
  input logic       clk_i,
  input logic       rst_n_i,
  bpu_gen2_if.slave bus
);
  localparam int PHT_N = 1 << IDX_BITS;
  localparam int BTB_N = 1 << BTB_BITS;
  localparam int TAG_W = XLEN - BTB_BITS - 2;

  logic [1:0]          pht [PHT_N];
  logic [IDX_BITS-1:0] ghr;
  logic                btb_valid  [BTB_N];
  logic [TAG_W-1:0]    btb_tag    [BTB_N];
  logic [XLEN-1:0]     btb_target [BTB_N];

  logic [IDX_BITS-1:0] pidx;
  logic [BTB_BITS-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                lk_hit, up_hit, btb_wr, btb_clr;
  logic [1:0]          pht_old, pht_new;

  always_comb begin
    pidx    = bus.pc_i[IDX_BITS+1:2] ^ ghr;
    lk_idx  = bus.pc_i[BTB_BITS+1:2];
    lk_tag  = bus.pc_i[XLEN-1:BTB_BITS+2];
    lk_hit  = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    up_idx  = bus.res_pc_i[BTB_BITS+1:2];
    up_tag  = bus.res_pc_i[XLEN-1:BTB_BITS+2];
    up_hit  = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
    btb_wr  = bus.res_valid_i && bus.res_taken_i && (bus.res_mispredict_i || !up_hit);
    btb_clr = bus.res_valid_i && bus.res_mispredict_i && !bus.res_taken_i && up_hit;
    pht_old = pht[bus.res_index_i];
    pht_new = pht_old;
    if (bus.res_taken_i && (pht_old != 2'b11))
      pht_new = pht_old + 2'b01;
    else if (!bus.res_taken_i && (pht_old != 2'b00))
      pht_new = pht_old - 2'b01;
  end

  // Flush wins over a coincident resolution; that update is dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ghr <= '0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (bus.flush_i) begin
      ghr <= '0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (bus.res_valid_i) begin
      pht[bus.res_index_i] <= pht_new;
      ghr <= {ghr[IDX_BITS-2:0], bus.res_taken_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
    end else if (bus.flush_i) begin
      for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
    end else if (btb_wr) begin
      btb_valid[up_idx] <= 1'b1;
    end else if (btb_clr) begin
      btb_valid[up_idx] <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (btb_wr && !bus.flush_i) begin
      btb_tag[up_idx]    <= up_tag;
      btb_target[up_idx] <= bus.res_target_i;
    end
  end

  logic unused_bits;
  assign unused_bits   = ^{bus.pc_valid_i, bus.res_type_i, bus.res_pc_i[1:0]};
  assign bus.pred_pc_o    = bus.pc_i;
  assign bus.pred_index_o = pidx;

`ifdef BPU_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [1:0]       btb_type [BTB_N];
  logic [XLEN-1:0]  ras [RAS_DEPTH];
  logic [PTR_W-1:0] ras_sp;
  logic [PTR_W:0]   ras_cnt;
  logic [1:0]       lk_type;
  logic             ras_push, ras_pop, ras_empty;

  always_ff @(posedge clk_i) begin
    if (btb_wr && !bus.flush_i) btb_type[up_idx] <= bus.res_type_i;
    if (ras_push && !bus.flush_i) ras[ras_sp] <= bus.pc_i + XLEN'(4);
  end

  always_comb begin
    lk_type   = btb_type[lk_idx];
    ras_empty = (ras_cnt == '0);
    ras_push  = bus.pc_valid_i && lk_hit && (lk_type == 2'b10);
    ras_pop   = bus.pc_valid_i && lk_hit && (lk_type == 2'b11) && !ras_empty;
    bus.pred_taken_o  = lk_hit && (pht[pidx][1] || (lk_type != 2'b00));
    bus.pred_target_o = '0;
    if (lk_hit)
      bus.pred_target_o = ((lk_type == 2'b11) && !ras_empty) ?
                          ras[ras_sp - PTR_W'(1)] : btb_target[lk_idx];
  end

  // sp points at the next free slot; when full a push overwrites the oldest.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ras_sp  <= '0;
      ras_cnt <= '0;
    end else if (bus.flush_i) begin
      ras_sp  <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_sp <= ras_sp + PTR_W'(1);
      if (ras_cnt != (PTR_W+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (PTR_W+1)'(1);
    end else if (ras_pop) begin
      ras_sp  <= ras_sp - PTR_W'(1);
      ras_cnt <= ras_cnt - (PTR_W+1)'(1);
    end
  end
`else
  always_comb begin
    bus.pred_taken_o  = lk_hit && pht[pidx][1];
    bus.pred_target_o = lk_hit ? btb_target[lk_idx] : '0;
  end
`endif
endmodule

// File: tb/tb_bpu_gen2.sv
// Self-checking bench for bpu_gen2: directed vector table, RAS sequence
// (BPU_RAS_EN builds), and randomized traffic against a reference model.
module tb_bpu_gen2;
  localparam int XLEN = 32, IDX = 5, BTBB = 4, RASD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  bpu_gen2_if #(.XLEN(XLEN), .IDX_BITS(IDX)) bus ();
  bpu_gen2 #(.XLEN(XLEN), .IDX_BITS(IDX), .BTB_BITS(BTBB), .RAS_DEPTH(RASD))
    dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic [4:0]  ridx;
    logic [31:0] rtgt;
    logic        rtk;
    logic        rmis;
    logic [1:0]  rtype;
    logic        pcv;
    logic [31:0] pc;
    logic        etk;
    logic [31:0] etgt;
    logic [4:0]  eidx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic fl, logic rv, logic [31:0] rpc, logic [4:0] ridx,
                              logic [31:0] rtgt, logic rtk, logic rmis, logic [1:0] rtype,
                              logic pcv, logic [31:0] pc, logic etk, logic [31:0] etgt,
                              logic [4:0] eidx);
    vec_t v;
    v.flush = fl; v.rv = rv; v.rpc = rpc; v.ridx = ridx; v.rtgt = rtgt; v.rtk = rtk;
    v.rmis = rmis; v.rtype = rtype; v.pcv = pcv; v.pc = pc; v.etk = etk; v.etgt = etgt;
    v.eidx = eidx;
    return v;
  endfunction

  task automatic apply(vec_t v);
    bus.flush_i = v.flush;       bus.res_valid_i = v.rv;       bus.res_pc_i = v.rpc;
    bus.res_index_i = v.ridx;    bus.res_target_i = v.rtgt;    bus.res_taken_i = v.rtk;
    bus.res_mispredict_i = v.rmis; bus.res_type_i = v.rtype;  bus.pc_valid_i = v.pcv;
    bus.pc_i = v.pc;
  endtask

  task automatic check(string nm, int n, logic etk, logic [31:0] etgt, logic [4:0] eidx);
    n_vec++;
    if (bus.pred_taken_o !== etk) begin
      n_bad++;
      $display("FAIL %s[%0d] taken got %b exp %b", nm, n, bus.pred_taken_o, etk);
    end
    if (bus.pred_target_o !== etgt) begin
      n_bad++;
      $display("FAIL %s[%0d] target got %h exp %h", nm, n, bus.pred_target_o, etgt);
    end
    if (bus.pred_index_o !== eidx) begin
      n_bad++;
      $display("FAIL %s[%0d] index got %h exp %h", nm, n, bus.pred_index_o, eidx);
    end
    if (bus.pred_pc_o !== bus.pc_i) begin
      n_bad++;
      $display("FAIL %s[%0d] pred_pc got %h exp %h", nm, n, bus.pred_pc_o, bus.pc_i);
    end
  endtask

  // Reference model: plain arrays plus a queue standing in for the RAS.
  int          m_pht [32];
  int          m_ghr;
  bit          m_v   [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int          m_ty  [16];
  int unsigned m_ras [$];

  function automatic void m_reset();
    m_ghr = 0;
    for (int i = 0; i < 32; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    m_ras.delete();
  endfunction

  task automatic m_cycle(vec_t v, output logic etk, output logic [31:0] etgt,
                         output logic [4:0] eidx);
    int unsigned pc = v.pc;
    int bi = (pc >> 2) % 16;
    int ri = (v.rpc >> 2) % 16;
    bit hit = m_v[bi] && (m_tag[bi] == (pc >> 6));
    bit rhit = m_v[ri] && (m_tag[ri] == (v.rpc >> 6));
    eidx = 5'(((pc >> 2) % 32) ^ m_ghr);
    etk  = hit && (m_pht[eidx] >= 2);
    etgt = hit ? m_tgt[bi] : 0;
`ifdef BPU_RAS_EN
    if (hit && m_ty[bi] != 0) etk = 1'b1;
    if (hit && m_ty[bi] == 3 && m_ras.size() > 0) begin
      etgt = m_ras[m_ras.size()-1];
      if (v.pcv) void'(m_ras.pop_back());
    end
    if (hit && m_ty[bi] == 2 && v.pcv) begin
      m_ras.push_back(pc + 4);
      if (m_ras.size() > RASD) void'(m_ras.pop_front());
    end
`endif
    if (v.flush) begin
      m_reset();
    end else if (v.rv) begin
      if (v.rtk) m_pht[v.ridx] = (m_pht[v.ridx] == 3) ? 3 : m_pht[v.ridx] + 1;
      else       m_pht[v.ridx] = (m_pht[v.ridx] == 0) ? 0 : m_pht[v.ridx] - 1;
      m_ghr = ((m_ghr << 1) | int'(v.rtk)) % 32;
      if (v.rtk && (v.rmis || !rhit)) begin
        m_v[ri] = 1'b1; m_tag[ri] = v.rpc >> 6; m_tgt[ri] = v.rtgt; m_ty[ri] = v.rtype;
      end else if (v.rmis && !v.rtk && rhit) begin
        m_v[ri] = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
  endfunction

  vec_t v;
  logic etk;
  logic [31:0] etgt;
  logic [4:0] eidx;

  initial begin
    v = mk(0,0,0,0,0,0,0,0,0,32'h100,0,0,0);
    apply(v);
    // reset state and basic training
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h100, 0,0,5'h00));
    tbl.push_back(mk(0,1,32'h100,5'd3,32'h200,1,1,0,0,32'h100, 0,0,5'h00));
    tbl.push_back(mk(0,1,32'h100,5'd3,32'h200,1,1,0,0,32'h100, 0,32'h200,5'h01));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h100, 1,32'h200,5'h03));
    // counter walks 3 -> 0 and saturates
    tbl.push_back(mk(0,1,32'h100,5'd3,0,0,0,0,0,32'h100, 1,32'h200,5'h03));
    tbl.push_back(mk(0,1,32'h100,5'd3,0,0,0,0,0,32'h100, 0,32'h200,5'h06));
    tbl.push_back(mk(0,1,32'h100,5'd3,0,0,0,0,0,32'h100, 0,32'h200,5'h0C));
    tbl.push_back(mk(0,1,32'h100,5'd3,0,0,0,0,0,32'h100, 0,32'h200,5'h18));
    tbl.push_back(mk(0,1,32'h100,5'd3,0,0,0,0,0,32'h100, 0,32'h200,5'h10));
    tbl.push_back(mk(0,1,32'h100,5'd31,0,1,0,0,0,32'h100, 0,32'h200,5'h00));
    tbl.push_back(mk(0,1,32'h100,5'd31,0,1,0,0,0,32'h100, 0,32'h200,5'h01));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h100, 0,32'h200,5'h03));
    // not-taken mispredict invalidates; alias misses on tag
    tbl.push_back(mk(0,1,32'h100,5'd30,0,0,1,0,0,32'h100, 0,32'h200,5'h03));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h100, 0,0,5'h06));
    tbl.push_back(mk(0,1,32'h100,5'd29,32'h300,1,1,0,0,32'h140, 0,0,5'h16));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h140, 0,0,5'h1D));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h100, 0,32'h300,5'h0D));
    // flush beats a coincident update
    tbl.push_back(mk(1,1,32'h100,5'd13,32'h400,1,1,0,0,32'h100, 0,32'h300,5'h0D));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h100, 0,0,5'h00));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #2 check("table", i, tbl[i].etk, tbl[i].etgt, tbl[i].eidx);
    end

`ifdef BPU_RAS_EN
    begin
      int g;
      logic [31:0] ret_exp [5];
      ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h2000};
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      g = 0;
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        apply(mk(0,1,32'(i*16),0,32'h1000,1,1,2'b10,0,32'h200,0,0,0));
        g = ((g << 1) | 1) % 32;
        @(negedge clk);
        apply(mk(0,0,0,0,0,0,0,0,1,32'(i*16),0,0,0));
        #2 check("ras_call", i, 1'b1, 32'h1000, 5'((i*4) ^ g));
      end
      @(negedge clk);
      apply(mk(0,1,32'h80,0,32'h2000,1,1,2'b11,0,32'h200,0,0,0));
      g = ((g << 1) | 1) % 32;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        apply(mk(0,0,0,0,0,0,0,0,1,32'h80,0,0,0));
        #2 check("ras_ret", i, 1'b1, ret_exp[i], 5'(g));
      end
    end
`endif

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      v = mk(($urandom_range(0, 39) == 0), $urandom_range(0, 1), rnd_pc(),
             5'($urandom_range(0, 31)), 32'($urandom_range(1, 255) << 2),
             $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
             $urandom_range(0, 1), rnd_pc(), 0, 0, 0);
      apply(v);
      #2;
      m_cycle(v, etk, etgt, eidx);
      check("random", n, etk, etgt, eidx);
      if (n == 1500) begin
        #1 rst_n = 1'b0;
        #1 check("async_rst", n, 1'b0, 32'h0, v.pc[6:2]);
        m_reset();
        @(negedge clk); rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
